// File: rtl/gray_rx_monitor_pkg.sv
// Shared types and helpers for the Gray counter receive monitor.
// gray2bin works on a wide word; zero-extended narrow codes decode correctly.
package gray_pkg;

  localparam int CBITS_DEF = 18;
  localparam int MAX_BITS  = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } state_e;

  function automatic logic [MAX_BITS-1:0] gray2bin(input logic [MAX_BITS-1:0] g);
    logic [MAX_BITS-1:0] b;
    b[MAX_BITS-1] = g[MAX_BITS-1];
    for (int i = MAX_BITS - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Legal step is a hold or a single increment, modulo 2^width.
  function automatic logic step_ok(input logic [MAX_BITS-1:0] prev,
                                   input logic [MAX_BITS-1:0] nxt,
                                   input int unsigned         width);
    logic [MAX_BITS-1:0] mask;
    logic [MAX_BITS-1:0] delta;
    mask  = (MAX_BITS'(1) << width) - MAX_BITS'(1);
    delta = (nxt - prev) & mask;
    return delta <= MAX_BITS'(1);
  endfunction

endpackage

// File: rtl/gray_rx_monitor_if.sv
// Sample/status bundle between the Gray counter consumer and downstream logic.
// master drives samples and clear, slave is the monitor.
interface gray_rx_monitor_if
  import gray_pkg::*;
#(
  parameter int CBITS     = CBITS_DEF,
  parameter int WRAP_BITS = 8,
  parameter int ERR_BITS  = 4
);
  logic [CBITS-1:0]     gray_in;
  logic                 in_vld;
  logic                 clr_err;
  logic [CBITS-1:0]     bin_out;
  logic                 bin_vld;
  logic                 zero_seen;
  logic                 wrap;
  logic [WRAP_BITS-1:0] wrap_cnt;
  logic                 err;
  logic [ERR_BITS-1:0]  err_cnt;
  logic                 locked;

  modport master (
    output gray_in, in_vld, clr_err,
    input  bin_out, bin_vld, zero_seen, wrap, wrap_cnt, err, err_cnt, locked
  );

  modport slave (
    input  gray_in, in_vld, clr_err,
    output bin_out, bin_vld, zero_seen, wrap, wrap_cnt, err, err_cnt, locked
  );
endinterface

// File: rtl/gray_rx_monitor_gray_to_bin.sv
// Combinational Gray-to-binary decoder, reusable by any consumer of the counter.
module gray_to_bin
  import gray_pkg::*;
#(
  parameter int CBITS = CBITS_DEF
) (
  input  logic [CBITS-1:0] gray_i,
  output logic [CBITS-1:0] bin_o
);

  logic [MAX_BITS-1:0] gray_ext;

  assign gray_ext = MAX_BITS'(gray_i);
  assign bin_o    = CBITS'(gray2bin(gray_ext));

endmodule

// File: rtl/gray_rx_monitor.sv
// Two-stage monitor: S1 registers the sample, S2 decodes, checks the step and
// registers all status outputs.
//
// state | meaning
// IDLE  | no reference; next sample becomes the reference unchecked
// TRACK | locked; every step checked for hold or +1, wraps counted
// ERROR | illegal step seen; samples still decoded, no checking until clr_err
module gray_rx_monitor
  import gray_pkg::*;
#(
  parameter int CBITS     = CBITS_DEF,
  parameter int WRAP_BITS = 8,
  parameter int ERR_BITS  = 4
) (
  input  logic             clk,
  input  logic             rst,
  gray_rx_monitor_if.slave bus
);

  logic [CBITS-1:0]     s1_gray_q;
  logic                 s1_vld_q;

  state_e               state_q,    state_d;
  logic [CBITS-1:0]     ref_q,      ref_d;
  logic [CBITS-1:0]     bin_out_q,  bin_out_d;
  logic                 bin_vld_q,  bin_vld_d;
  logic                 zero_q,     zero_d;
  logic                 wrap_q,     wrap_d;
  logic [WRAP_BITS-1:0] wrap_cnt_q, wrap_cnt_d;
  logic                 err_q,      err_d;
  logic [ERR_BITS-1:0]  err_cnt_q,  err_cnt_d;

  logic [CBITS-1:0]     bin_new;
  logic                 legal;
  logic                 step_one;
  logic                 bin_zero;
  logic                 is_wrap;

  gray_to_bin #(.CBITS(CBITS)) u_dec (
    .gray_i (s1_gray_q),
    .bin_o  (bin_new)
  );

  assign bin_zero = (bin_new == '0);
  assign step_one = ((bin_new - ref_q) == CBITS'(1));
  assign legal    = step_ok(MAX_BITS'(ref_q), MAX_BITS'(bin_new), CBITS);
  assign is_wrap  = (&ref_q) && bin_zero;

  always_comb begin
    state_d    = state_q;
    ref_d      = ref_q;
    bin_out_d  = bin_out_q;
    bin_vld_d  = 1'b0;
    zero_d     = 1'b0;
    wrap_d     = 1'b0;
    wrap_cnt_d = wrap_cnt_q;
    err_d      = err_q;
    err_cnt_d  = err_cnt_q;

    if (s1_vld_q) begin
      bin_vld_d = 1'b1;
      bin_out_d = bin_new;
      ref_d     = bin_new;
    end

    // A clear overrides any check on the sample leaving S2 this cycle.
    if (bus.clr_err) begin
      state_d    = IDLE;
      err_d      = 1'b0;
      wrap_cnt_d = '0;
      zero_d     = s1_vld_q && bin_zero;
    end else if (s1_vld_q) begin
      unique case (state_q)
        IDLE: begin
          zero_d  = bin_zero;
          state_d = TRACK;
        end
        TRACK: begin
          if (legal) begin
            zero_d = bin_zero && step_one;
            wrap_d = is_wrap;
            if (is_wrap) wrap_cnt_d = wrap_cnt_q + WRAP_BITS'(1);
          end else begin
            err_d   = 1'b1;
            state_d = ERROR;
            if (!(&err_cnt_q)) err_cnt_d = err_cnt_q + ERR_BITS'(1);
          end
        end
        ERROR: begin
          zero_d = bin_zero;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_gray_q  <= '0;
      s1_vld_q   <= 1'b0;
      state_q    <= IDLE;
      ref_q      <= '0;
      bin_out_q  <= '0;
      bin_vld_q  <= 1'b0;
      zero_q     <= 1'b0;
      wrap_q     <= 1'b0;
      wrap_cnt_q <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      s1_gray_q  <= bus.gray_in;
      s1_vld_q   <= bus.in_vld;
      state_q    <= state_d;
      ref_q      <= ref_d;
      bin_out_q  <= bin_out_d;
      bin_vld_q  <= bin_vld_d;
      zero_q     <= zero_d;
      wrap_q     <= wrap_d;
      wrap_cnt_q <= wrap_cnt_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.bin_out   = bin_out_q;
  assign bus.bin_vld   = bin_vld_q;
  assign bus.zero_seen = zero_q;
  assign bus.wrap      = wrap_q;
  assign bus.wrap_cnt  = wrap_cnt_q;
  assign bus.err       = err_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.locked    = (state_q == TRACK);

endmodule

// File: tb/tb_gray_rx_monitor.sv
// Scoreboard bench for gray_rx_monitor at CBITS=4: directed scenarios plus
// random stimulus, checked against a table-driven reference model.
module tb_gray_rx_monitor;

  localparam int CB = 4;
  localparam int WB = 8;
  localparam int EB = 4;
  localparam int NV = 1 << CB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_seen = 1'b0;

  always #5 clk = ~clk;

  gray_rx_monitor_if #(.CBITS(CB), .WRAP_BITS(WB), .ERR_BITS(EB)) bus ();

  gray_rx_monitor #(.CBITS(CB), .WRAP_BITS(WB), .ERR_BITS(EB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int bin;
    bit z;
    bit w;
    int wc;
    bit e;
    int ec;
    bit lk;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  bit   end_req  = 1'b0;
  bit   end_done = 1'b0;

  // Reference model: state 0 = no reference, 1 = locked, 2 = faulted.
  int gray_of[NV];
  int m_st, m_prev, m_wc, m_err, m_ec;
  bit pend_v;
  int pend_g;

  function automatic int bin_of_gray(int g);
    for (int n = 0; n < NV; n++) begin
      if (gray_of[n] == g) return n;
    end
    return -1;
  endfunction

  task automatic chk(string nm, int act, int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  always @(posedge clk) rst_seen <= rst;

  always @(negedge clk) begin
    if (rst_seen) begin
      chk("rst_bin_out",   int'(bus.bin_out),   0);
      chk("rst_wrap_cnt",  int'(bus.wrap_cnt),  0);
      chk("rst_err",       int'(bus.err),       0);
      chk("rst_err_cnt",   int'(bus.err_cnt),   0);
      chk("rst_locked",    int'(bus.locked),    0);
    end
    if (bus.bin_vld) begin
      if (exp_q.size() == 0) begin
        chk("vld_without_expect", int'(bus.bin_vld), 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("bin_out",   int'(bus.bin_out),   mon_e.bin);
        chk("zero_seen", int'(bus.zero_seen), int'(mon_e.z));
        chk("wrap",      int'(bus.wrap),      int'(mon_e.w));
        chk("wrap_cnt",  int'(bus.wrap_cnt),  mon_e.wc);
        chk("err",       int'(bus.err),       int'(mon_e.e));
        chk("err_cnt",   int'(bus.err_cnt),   mon_e.ec);
        chk("locked",    int'(bus.locked),    int'(mon_e.lk));
      end
    end else begin
      chk("zero_no_vld", int'(bus.zero_seen), 0);
      chk("wrap_no_vld", int'(bus.wrap),      0);
    end
    if (end_req && !end_done) begin
      chk("queue_drained", exp_q.size(), 0);
      end_done = 1'b1;
    end
  end

  // Drive one cycle of inputs; the model resolves the sample presented last
  // cycle, since clr_err and rst act when that sample reaches S2.
  task automatic drive(bit v, int g, bit c, bit r);
    exp_t e;
    int   b, d;
    bus.in_vld  = v;
    bus.gray_in = CB'(g);
    bus.clr_err = c;
    rst         = r;
    if (r) begin
      m_st = 0; m_prev = 0; m_wc = 0; m_err = 0; m_ec = 0;
      pend_v = 1'b0;
    end else begin
      if (pend_v) begin
        b = bin_of_gray(pend_g);
        d = (b - m_prev + NV) % NV;
        e.z = 1'b0;
        e.w = 1'b0;
        if (c) begin
          e.z = (b == 0);
          m_st = 0; m_err = 0; m_wc = 0;
        end else if (m_st == 0) begin
          e.z = (b == 0);
          m_st = 1;
        end else if (m_st == 1) begin
          if (d <= 1) begin
            e.z = (b == 0) && (d == 1);
            e.w = (m_prev == NV - 1) && (b == 0);
            if (e.w) m_wc = (m_wc + 1) % (1 << WB);
          end else begin
            m_err = 1;
            if (m_ec < (1 << EB) - 1) m_ec++;
            m_st = 2;
          end
        end else begin
          e.z = (b == 0);
        end
        m_prev = b;
        e.bin = b;
        e.wc  = m_wc;
        e.e   = (m_err != 0);
        e.ec  = m_ec;
        e.lk  = (m_st == 1);
        exp_q.push_back(e);
      end else if (c) begin
        m_st = 0; m_err = 0; m_wc = 0;
      end
      pend_v = v;
      pend_g = g;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic go(int b);
    drive(1'b1, gray_of[b], 1'b0, 1'b0);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic reset_dut();
    drive(1'b0, 0, 1'b0, 1'b1);
    drive(1'b0, 0, 1'b0, 1'b1);
  endtask

  initial begin
    int cur;
    bit rv, rc, vv;
    int k;
    for (int n = 0; n < NV; n++) gray_of[n] = n ^ (n >> 1);

    // Full count with one wrap.
    reset_dut();
    for (int n = 0; n < NV; n++) go(n);
    go(0);
    idle(3);

    // Holds and gaps.
    reset_dut();
    go(2); go(2); go(2);
    idle(4);
    go(3);
    idle(3);

    // Forward jump, then decoding continues in the faulted state.
    reset_dut();
    go(4); go(5); go(9); go(10);
    idle(3);

    // Backward step, then clear while the faulted state sees another jump.
    reset_dut();
    go(5); go(6); go(5); go(12);
    drive(1'b1, gray_of[13], 1'b1, 1'b0);
    go(14);
    idle(3);

    // Clear while locked beats the pending illegal step.
    reset_dut();
    go(1); go(2); go(9);
    drive(1'b0, 0, 1'b1, 1'b0);
    go(10); go(11);
    idle(3);

    // Error counter saturation.
    reset_dut();
    for (int i = 0; i < 20; i++) begin
      go(3); go(8);
      idle(1);
      drive(1'b0, 0, 1'b1, 1'b0);
    end
    go(0); go(7);
    idle(2);

    // Reset with two samples in flight.
    go(5);
    drive(1'b1, gray_of[6], 1'b0, 1'b1);
    idle(4);

    // Randomised traffic.
    reset_dut();
    cur = 0;
    for (int i = 0; i < 500; i++) begin
      k  = $urandom_range(199);
      rv = (k == 0);
      rc = (k > 0) && (k < 8);
      vv = ($urandom_range(99) < 80);
      k  = $urandom_range(99);
      if (k < 30) cur = cur;
      else if (k < 88) cur = (cur + 1) % NV;
      else cur = $urandom_range(NV - 1);
      drive(vv, gray_of[cur], rc, rv);
    end
    idle(4);

    end_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
